dual_issue_fetch_queue: RTL

Parametrised instruction fetch queue between local-store instruction fetch and the dual-issue decode stage. It accepts up to LANES instructions per cycle with their PCs and presents the oldest LANES instructions as issue slots. Decode consumes 0..LANES of them per cycle, so single-issue cycles on dependency or pipe conflict need no re-fetch. Branch-taken flush empties it in one cycle, and empty slots are padded with NOP/LNOP so decode always sees legal encodings.

---
 rtl/dual_issue_fetch_queue.sv | 114 +++++++++++
 1 files changed

// File: rtl/dual_issue_fetch_queue.sv
// Instruction fetch queue feeding the dual-issue decode stage: multi-lane push, 0..LANES pop,
// one-cycle flush, and NOP/LNOP padding so decode always sees legal encodings in empty slots.
module dual_issue_fetch_queue #(
   parameter int DEPTH  = 16,
   parameter int LANES  = 2,
   parameter int INST_W = 32,
   parameter int PC_W   = 15
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic [$clog2(LANES+1)-1:0]   in_count,
   input  logic [LANES*INST_W-1:0]      in_inst,
   input  logic [PC_W-1:0]              in_pc,
   output logic                         in_ready,
   output logic [LANES*INST_W-1:0]      out_inst,
   output logic [PC_W-1:0]              out_pc,
   output logic [$clog2(LANES+1)-1:0]   out_count,
   input  logic [$clog2(LANES+1)-1:0]   pop_count,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         pop_err
);

   localparam int CW = $clog2(LANES+1);
   localparam int PW = $clog2(DEPTH);
   localparam int NW = $clog2(DEPTH+1);

   localparam logic [INST_W-1:0] NOP  = INST_W'(32'h4020_0000);
   localparam logic [INST_W-1:0] LNOP = INST_W'(32'h0020_0000);

   logic [INST_W-1:0] instMem [DEPTH];
   logic [PC_W-1:0]   pcMem   [DEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [NW-1:0] count_q, count_d;
   logic          popErr_q, popErr_d;

   logic [CW-1:0] pushCount;
   logic [CW-1:0] popCount;
   logic [CW-1:0] outCount;
   logic          pushEn;
   logic [PW-1:0] wrIdx  [LANES];
   logic [PC_W-1:0] lanePc [LANES];

   // Occupancy-derived handshakes; in_ready deliberately ignores any same-cycle pop
   always_comb begin
      in_ready  = (count_q <= NW'(DEPTH - LANES));
      outCount  = (count_q >= NW'(LANES)) ? CW'(LANES) : CW'(count_q);
      pushCount = (in_count > CW'(LANES)) ? CW'(LANES) : in_count;
      pushEn    = in_ready && (pushCount != '0) && !flush;
      popCount  = (pop_count > outCount) ? outCount : pop_count;
      for (int k = 0; k < LANES; k++) begin
         wrIdx[k]  = tail_q + PW'(k);
         lanePc[k] = in_pc + PC_W'(4 * k);
      end
   end

   always_comb begin
      head_d   = head_q + PW'(popCount);
      tail_d   = tail_q + (pushEn ? PW'(pushCount) : '0);
      count_d  = count_q + (pushEn ? NW'(pushCount) : '0) - NW'(popCount);
      popErr_d = popErr_q | (pop_count > outCount);
      // Flush wins over everything, but the error flag survives it
      if (flush) begin
         head_d   = '0;
         tail_d   = '0;
         count_d  = '0;
         popErr_d = popErr_q;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         popErr_q <= 1'b0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         popErr_q <= popErr_d;
      end
   end

   always_ff @(posedge clock) begin
      if (pushEn) begin
         for (int k = 0; k < LANES; k++) begin
            if (CW'(k) < pushCount) begin
               instMem[wrIdx[k]] <= in_inst[k*INST_W +: INST_W];
               pcMem[wrIdx[k]]   <= lanePc[k];
            end
         end
      end
   end

   // Issue slots beyond the held entries carry NOP on lane 0 and LNOP elsewhere
   always_comb begin
      out_inst = '0;
      for (int k = 0; k < LANES; k++) begin
         if (NW'(k) < count_q) begin
            out_inst[k*INST_W +: INST_W] = instMem[head_q + PW'(k)];
         end else begin
            out_inst[k*INST_W +: INST_W] = (k == 0) ? NOP : LNOP;
         end
      end
      out_pc    = (count_q != '0) ? pcMem[head_q] : '0;
      out_count = outCount;
      count     = count_q;
      pop_err   = popErr_q;
   end

endmodule
